// File: rtl/router_output_port.sv
// Router output port: fetches a length-prefixed packet from the packet buffer and streams it out
// with valid/ready handshaking. Define ROUTER_OUT_PARITY_EN to add the out_parity output.
module router_output_port #(
    parameter int UWIDTH = 8,
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 4
) (
    input  logic              clk2,
    input  logic              rst,
    input  logic              port_en,
    input  logic [ADDR_W-1:0] port_raddr,
    output logic              port_done,
    output logic              busy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [UWIDTH-1:0] mem_rdata,
    output logic [UWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef ROUTER_OUT_PARITY_EN
    output logic              out_parity,
`endif
    output logic              out_last
);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [LEN_W:0]    count, count_nxt;
    logic [LEN_W:0]    total, total_nxt;
    logic [LEN_W:0]    word_num, fetch_total;
    logic [UWIDTH-1:0] data_nxt;
    logic              valid_nxt, last_nxt;
    logic              xfer;

    // One extra bit so a maximal length field (all ones) plus the header word cannot wrap.
    function automatic logic [LEN_W:0] header_total(input logic [UWIDTH-1:0] hdr);
        return {1'b0, hdr[LEN_W-1:0]} + 1'b1;
    endfunction

    assign busy      = (state != IDLE);
    assign port_done = (state == DONE);

    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr_q;
        count_nxt   = count;
        total_nxt   = total;
        data_nxt    = out_data;
        valid_nxt   = out_valid;
        last_nxt    = out_last;
        mem_rd_en   = 1'b0;
        mem_addr    = addr_q;
        xfer        = out_valid && out_ready;
        word_num    = count + 1'b1;
        fetch_total = (count == '0) ? header_total(mem_rdata) : total;

        case (state)
            IDLE: begin
                if (port_en) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = port_raddr;
                    addr_nxt  = port_raddr;
                    count_nxt = '0;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                data_nxt  = mem_rdata;
                valid_nxt = 1'b1;
                total_nxt = fetch_total;
                last_nxt  = (word_num == fetch_total);
                state_nxt = SEND;
            end
            SEND: begin
                if (xfer) begin
                    count_nxt = word_num;
                    valid_nxt = 1'b0;
                    last_nxt  = 1'b0;
                    if (word_num == total) begin
                        state_nxt = DONE;
                    end else begin
                        addr_nxt  = addr_q + 1'b1;
                        mem_rd_en = 1'b1;
                        mem_addr  = addr_q + 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Reset wins over a same-cycle request: no read may escape while rst is held.
        if (rst) begin
            mem_rd_en = 1'b0;
            mem_addr  = addr_q;
        end
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            count     <= '0;
            total     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr_q    <= addr_nxt;
            count     <= count_nxt;
            total     <= total_nxt;
            out_data  <= data_nxt;
            out_valid <= valid_nxt;
            out_last  <= last_nxt;
        end
    end

`ifdef ROUTER_OUT_PARITY_EN
    function automatic logic even_parity(input logic [UWIDTH-1:0] d);
        return ^d;
    endfunction

    always_ff @(posedge clk2) begin
        if (rst) begin
            out_parity <= 1'b0;
        end else begin
            out_parity <= even_parity(data_nxt);
        end
    end
`endif

endmodule

// File: tb/tb_router_output_port.sv
// Randomized self-checking bench for router_output_port: a packet-level model predicts the word
// stream, read addresses and done pulse; cycle checks cover reset, stalls and busy behaviour.
module tb_router_output_port;
    localparam int UWIDTH = 8;
    localparam int ADDR_W = 4;
    localparam int LEN_W  = 4;
    localparam int DEPTH  = 16;

    logic              clk2 = 1'b0;
    logic              rst;
    logic              port_en;
    logic [ADDR_W-1:0] port_raddr;
    logic              port_done;
    logic              busy;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [UWIDTH-1:0] mem_rdata;
    logic [UWIDTH-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
`ifdef ROUTER_OUT_PARITY_EN
    logic              out_parity;
`endif

    logic [UWIDTH-1:0] mem [DEPTH];
    int checks = 0;
    int errors = 0;

    router_output_port #(.UWIDTH(UWIDTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk2       (clk2),
        .rst        (rst),
        .port_en    (port_en),
        .port_raddr (port_raddr),
        .port_done  (port_done),
        .busy       (busy),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef ROUTER_OUT_PARITY_EN
        .out_parity (out_parity),
`endif
        .out_last   (out_last)
    );

    always #5 clk2 = ~clk2;

    // Packet buffer: synchronous read, data one cycle after the strobe.
    always @(posedge clk2) begin
        if (mem_rd_en === 1'b1) mem_rdata <= mem[mem_addr];
    end

    task automatic cyc();
        @(posedge clk2);
        #1;
    endtask

    task automatic fill_mem_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; port_en = 1'b1; port_raddr = 4'd7; out_ready = 1'b1;
        cyc(); cyc();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
        checks++; if (port_done !== 1'b0) begin errors++; $display("FAIL reset_port_done got %b want 0", port_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_priority_rd_en got %b want 0", mem_rd_en); end
        checks++; if (mem_addr !== 4'd0) begin errors++; $display("FAIL reset_mem_addr got %0d want 0", mem_addr); end
`ifdef ROUTER_OUT_PARITY_EN
        checks++; if (out_parity !== 1'b0) begin errors++; $display("FAIL reset_out_parity got %b want 0", out_parity); end
`endif
        port_en = 1'b0; rst = 1'b0;
        cyc();
    endtask

    // Sends one packet starting at a; ready_rand randomizes out_ready, stall_at holds out_ready low
    // for 5 cycles on that word index, noise fires extra port_en requests while busy.
    task automatic run_packet(input logic [ADDR_W-1:0] a, input bit ready_rand, input int stall_at,
                              input bit noise, input string name);
        logic [UWIDTH-1:0] exp_data[$];
        bit                exp_last[$];
        logic [ADDR_W-1:0] exp_addr[$];
        logic [UWIDTH-1:0] got_data[$];
        bit                got_last[$];
        logic [ADDR_W-1:0] got_addr[$];
        logic [ADDR_W-1:0] ai;
        logic [UWIDTH-1:0] snap_data;
        logic              snap_valid, snap_last;
        int len, first_k, last_k, done_k, done_cnt, stall_left;
        bit done, stalling;

        len = int'(mem[a][LEN_W-1:0]);
        for (int i = 0; i <= len; i++) begin
            ai = a + ADDR_W'(i);
            exp_addr.push_back(ai);
            exp_data.push_back(mem[ai]);
            exp_last.push_back(i == len);
        end

        first_k = -1; last_k = -1; done_k = -1; done_cnt = 0; stall_left = 5; done = 0;
        snap_data = '0; snap_valid = 1'b0; snap_last = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            if (k == 0) begin
                port_en = 1'b1; port_raddr = a;
            end else begin
                port_en    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                port_raddr = noise ? ADDR_W'($urandom) : a;
            end
            stalling = (stall_at >= 0) && (got_data.size() == stall_at) && (stall_left > 0)
                       && (out_valid === 1'b1);
            if (stalling) out_ready = 1'b0;
            else out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stalling) begin
                if (stall_left == 5) begin
                    snap_data = out_data; snap_valid = out_valid; snap_last = out_last;
                end else begin
                    checks++; if ({out_data, out_valid, out_last} !== {snap_data, snap_valid, snap_last}) begin
                        errors++; $display("FAIL %s_stall_hold got %h/%b/%b want %h/%b/%b", name,
                                           out_data, out_valid, out_last, snap_data, snap_valid, snap_last);
                    end
                end
                checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL %s_stall_rd_en got %b want 0", name, mem_rd_en); end
                stall_left--;
            end
            checks++; if (out_last === 1'b1 && out_valid !== 1'b1) begin
                errors++; $display("FAIL %s_last_without_valid got last=1 valid=%b want last=0", name, out_valid);
            end
`ifdef ROUTER_OUT_PARITY_EN
            if (out_valid === 1'b1) begin
                checks++; if (out_parity !== ^out_data) begin
                    errors++; $display("FAIL %s_parity data=%h got %b want %b", name, out_data, out_parity, ^out_data);
                end
            end
`endif
            if (mem_rd_en === 1'b1) got_addr.push_back(mem_addr);
            if (out_valid === 1'b1 && first_k < 0) first_k = k;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                got_data.push_back(out_data); got_last.push_back(out_last); last_k = k;
            end
            if (port_done === 1'b1) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
                done = 1;
            end
            if (!done) begin
                @(posedge clk2);
                #1;
            end
        end
        port_en = 1'b0;

        checks++; if (!done) begin errors++; $display("FAIL %s_timeout got no port_done want port_done within 400 cycles", name); end
        checks++; if (first_k != 2) begin errors++; $display("FAIL %s_latency got %0d want 2", name, first_k); end
        checks++; if (done_k != last_k + 1) begin errors++; $display("FAIL %s_done_timing got cycle %0d want %0d", name, done_k, last_k + 1); end
        checks++; if (got_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL %s_read_count got %0d want %0d", name, got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++; if (got_addr[i] !== exp_addr[i]) begin
                errors++; $display("FAIL %s_read_addr[%0d] got %0d want %0d", name, i, got_addr[i], exp_addr[i]);
            end
        end
        checks++; if (got_data.size() != exp_data.size()) begin
            errors++; $display("FAIL %s_word_count got %0d want %0d", name, got_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                errors++; $display("FAIL %s_word[%0d] got %h last=%b want %h last=%b", name, i,
                                   got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end

        cyc();
        checks++; if (port_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL %s_after_done got done=%b busy=%b want 0/0", name, port_done, busy);
        end
        cyc();
    endtask

    task automatic test_basic();
        fill_mem_random();
        mem[4] = 8'h02; mem[5] = 8'hA1; mem[6] = 8'hB2;
        run_packet(4'd4, 1'b0, -1, 1'b0, "basic");
    endtask

    task automatic test_single_word();
        fill_mem_random();
        mem[9] = 8'h00;
        run_packet(4'd9, 1'b0, -1, 1'b0, "single");
    endtask

    task automatic test_wrap();
        fill_mem_random();
        mem[14] = 8'h03;
        run_packet(4'd14, 1'b0, -1, 1'b0, "wrap");
    endtask

    task automatic test_stall();
        fill_mem_random();
        mem[2] = 8'h04;
        run_packet(4'd2, 1'b0, 2, 1'b0, "stall");
    endtask

    task automatic test_busy_ignore();
        fill_mem_random();
        mem[5] = 8'h07;
        run_packet(4'd5, 1'b1, -1, 1'b1, "busy_ignore");
    endtask

    task automatic test_reset_mid();
        fill_mem_random();
        mem[3] = 8'h06;
        port_en = 1'b1; port_raddr = 4'd3; out_ready = 1'b0;
        cyc();
        port_raddr = 4'd10;
        cyc();
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h06) begin
            errors++; $display("FAIL rstmid_pre got valid=%b data=%h want 1/06", out_valid, out_data);
        end
        rst = 1'b1;
        cyc();
        #1;
        checks++; if ({out_valid, out_last, port_done, busy, mem_rd_en} !== 5'b0 || out_data !== 8'h00 || mem_addr !== 4'd0) begin
            errors++; $display("FAIL rstmid_outputs got v=%b l=%b d=%b b=%b r=%b data=%h addr=%0d want all 0",
                               out_valid, out_last, port_done, busy, mem_rd_en, out_data, mem_addr);
        end
        rst = 1'b0; port_en = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            checks++; if ({out_valid, port_done, mem_rd_en, busy} !== 4'b0) begin
                errors++; $display("FAIL rstmid_quiet[%0d] got v=%b d=%b r=%b b=%b want 0", k, out_valid, port_done, mem_rd_en, busy);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            fill_mem_random();
            run_packet(ADDR_W'($urandom), 1'b1, ($urandom_range(0, 3) == 0) ? 1 : -1,
                       1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        rst = 1'b1; port_en = 1'b0; port_raddr = '0; out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_single_word();
        test_wrap();
        test_stall();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
